// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo buffer: byte width and echo FSM state encoding.
package uart_pkg;

    localparam int UART_DW = 8;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_ACK  = 2'd2,
        S_WAIT_DONE = 2'd3
    } echo_state_t;

endpackage

// File: rtl/uart_echo_buf_sync_fifo.sv
// Synchronous FIFO with first-word fall-through read port, occupancy count and
// full/empty flags. A push while full is accepted only when a pop frees a slot in the same cycle.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = UART_DW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_CNT);
    assign w_do_pop  = pop && !w_empty;
    assign w_do_push = push && (!w_full || w_do_pop);

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign empty = w_empty;
    assign full  = w_full;

endmodule

// File: rtl/uart_echo_buf.sv
// Echo buffer: queues received bytes and hands them one at a time to a UART transmitter,
// retrying a byte whose start request is not acknowledged within ACK_TIMEOUT cycles.
//
//   state       | meaning
//   ------------+-------------------------------------------------------------
//   S_IDLE      | waiting for a stored byte and an idle transmitter
//   S_LAUNCH    | tx_start pulse; head byte already on tx_data
//   S_WAIT_ACK  | waiting for tx_idle to drop; timeout counter running
//   S_WAIT_DONE | byte accepted and popped; waiting for transmitter to finish
module uart_echo_buf
    import uart_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [UART_DW-1:0]     rx_data,
    input  logic                   rx_valid,
    input  logic                   tx_idle,
    input  logic                   clr_ovr,
    output logic [UART_DW-1:0]     tx_data,
    output logic                   tx_start,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic                   overrun
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(ACK_TIMEOUT);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    echo_state_t r_state;
    echo_state_t w_state_nxt;

    logic [TW-1:0]      r_tmo;
    logic [TW-1:0]      w_tmo_nxt;
    logic [UART_DW-1:0] r_tx_data;
    logic               r_ovr;

    logic               w_pop;
    logic               w_load_tx;
    logic               w_drop;
    logic [UART_DW-1:0] w_fifo_dout;
    logic               w_empty;
    logic               w_full;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_DW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_valid),
        .pop   (w_pop),
        .din   (rx_data),
        .dout  (w_fifo_dout),
        .count (count),
        .empty (w_empty),
        .full  (w_full)
    );

    // The ack window spans ACK_TIMEOUT WAIT_ACK cycles: the counter steps down
    // from ACK_TIMEOUT and the retry fires on the cycle its decrement reaches zero.
    always_comb begin
        w_state_nxt = r_state;
        w_tmo_nxt   = r_tmo;
        w_pop       = 1'b0;
        w_load_tx   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && tx_idle) begin
                    w_state_nxt = S_LAUNCH;
                    w_load_tx   = 1'b1;
                end
            end
            S_LAUNCH: begin
                w_state_nxt = S_WAIT_ACK;
                w_tmo_nxt   = TMO_LOAD;
            end
            S_WAIT_ACK: begin
                if (!tx_idle) begin
                    w_state_nxt = S_WAIT_DONE;
                    w_pop       = 1'b1;
                end else if (r_tmo <= TMO_ONE) begin
                    w_state_nxt = S_IDLE;
                    w_tmo_nxt   = '0;
                end else begin
                    w_tmo_nxt   = r_tmo - TMO_ONE;
                end
            end
            S_WAIT_DONE: begin
                if (tx_idle) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_tmo     <= TMO_LOAD;
            r_tx_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tmo   <= w_tmo_nxt;
            if (w_load_tx) begin
                r_tx_data <= w_fifo_dout;
            end
        end
    end

    // A dropped byte outranks a simultaneous clear so no loss goes unreported.
    assign w_drop = rx_valid && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovr <= 1'b0;
        end else if (w_drop) begin
            r_ovr <= 1'b1;
        end else if (clr_ovr) begin
            r_ovr <= 1'b0;
        end
    end

    assign tx_start = (r_state == S_LAUNCH);
    assign tx_data  = r_tx_data;
    assign empty    = w_empty;
    assign full     = w_full;
    assign overrun  = r_ovr;

endmodule

// File: tb/tb_uart_echo_buf.sv
// Bench for uart_echo_buf: directed scenarios followed by randomized traffic
// checked against a queue-based model of the echo buffer.
module tb_uart_echo_buf;

    localparam int DEPTH       = 16;
    localparam int ACK_TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_idle;
    logic       clr_ovr;
    logic [7:0] tx_data;
    logic       tx_start;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q[$];
    bit         found;
    bit         exp_ovr;
    bit         awaiting;
    bit         pop_now;
    bit         full_before;
    int         busy_left;
    int         ack_delay;
    int         gap;
    int         n_start;

    always #5 clk = ~clk;

    uart_echo_buf #(
        .DEPTH       (DEPTH),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_idle  (tx_idle),
        .clr_ovr  (clr_ovr),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overrun  (overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input int max_cyc, output bit got);
        got = tx_start;
        for (int k = 0; k < max_cyc && !got; k++) begin
            tick();
            got = tx_start;
        end
    endtask

    // Transmitter that acknowledges in the first WAIT_ACK cycle and stays busy one more cycle.
    task automatic xmit_one(input logic [7:0] exp_b, input string tag);
        bit got;
        tx_idle = 1'b1;
        wait_start(40, got);
        chk({tag, "_start"}, got, 1);
        if (got) begin
            chk({tag, "_data"}, tx_data, exp_b);
            tx_idle = 1'b0;
            tick();
            tick();
            tx_idle = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_idle  = 1'b1;
        clr_ovr  = 1'b0;
        tick();
        tick();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_start", tx_start, 0);
        chk("rst_data", tx_data, 8'h00);
        rst_n = 1'b1;

        // Single byte: latency N+2
        tick();
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        chk("single_n1_count", count, 1);
        chk("single_n1_start", tx_start, 0);
        tick();
        chk("single_n2_start", tx_start, 1);
        chk("single_n2_data", tx_data, 8'hA5);
        tx_idle = 1'b0;
        tick();
        chk("single_n3_start", tx_start, 0);
        tick();
        chk("single_count_done", count, 0);
        tx_idle = 1'b1;
        tick();
        tick();
        chk("single_empty", empty, 1);
        chk("single_no_restart", tx_start, 0);

        // Burst of 16 with transmitter busy
        tx_idle = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rx_data  = 8'(i);
            rx_valid = 1'b1;
            tick();
        end
        rx_valid = 1'b0;
        chk("burst_count", count, 16);
        chk("burst_full", full, 1);
        chk("burst_empty", empty, 0);

        // Overrun on 17th byte
        rx_data  = 8'hFF;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        chk("ovr_set", overrun, 1);
        chk("ovr_count", count, 16);
        tick();
        chk("ovr_sticky", overrun, 1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        chk("ovr_clear", overrun, 0);

        // Pop and push in the same cycle while full
        tx_idle = 1'b1;
        wait_start(10, found);
        chk("simul_start", found, 1);
        chk("simul_data", tx_data, 8'h00);
        tick();
        tx_idle  = 1'b0;
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        chk("simul_count", count, 16);
        chk("simul_ovr", overrun, 0);
        chk("simul_full", full, 1);
        tick();
        tx_idle = 1'b1;
        for (int i = 1; i < 16; i++) begin
            xmit_one(8'(i), "burst_order");
        end
        xmit_one(8'h55, "simul_last");
        tick();
        chk("drain_count", count, 0);
        chk("drain_empty", empty, 1);
        wait_start(20, found);
        chk("no_ff_sent", found, 0);

        // Timeout and retry
        rx_data  = 8'h3C;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        wait_start(10, found);
        chk("tmo_first_start", found, 1);
        gap   = 0;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            gap++;
            found = tx_start;
        end
        chk("tmo_gap", gap, ACK_TIMEOUT + 2);
        chk("tmo_retry_data", tx_data, 8'h3C);
        chk("tmo_count", count, 1);
        xmit_one(8'h3C, "tmo_finish");
        tick();
        chk("tmo_empty", empty, 1);

        // Reset while in WAIT_DONE with five bytes stored
        tx_idle = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rx_data  = 8'h81 + 8'(i);
            rx_valid = 1'b1;
            tick();
        end
        rx_valid = 1'b0;
        tx_idle  = 1'b1;
        wait_start(10, found);
        chk("mid_start", found, 1);
        tick();
        tx_idle = 1'b0;
        tick();
        tick();
        chk("mid_count", count, 5);
        chk("mid_data", tx_data, 8'h81);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_full", full, 0);
        chk("mid_rst_ovr", overrun, 0);
        chk("mid_rst_start", tx_start, 0);
        chk("mid_rst_data", tx_data, 8'h00);
        tx_idle = 1'b1;
        n_start = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (tx_start) n_start++;
        end
        chk("mid_no_start", n_start, 0);

        // Randomized traffic against queue model
        q.delete();
        exp_ovr   = 1'b0;
        awaiting  = 1'b0;
        busy_left = 0;
        ack_delay = 0;
        for (int cyc = 0; cyc < 3400; cyc++) begin
            chk("rand_count", count, q.size());
            chk("rand_empty", empty, q.size() == 0);
            chk("rand_full", full, q.size() == DEPTH);
            chk("rand_ovr", overrun, exp_ovr);
            pop_now = 1'b0;
            if (tx_start) begin
                chk("rand_start_legal", awaiting || (busy_left != 0), 0);
                chk("rand_start_nonempty", q.size() != 0, 1);
                if (q.size() != 0) chk("rand_data", tx_data, q[0]);
                awaiting  = 1'b1;
                ack_delay = $urandom_range(1, 3);
                tx_idle   = 1'b1;
            end else if (awaiting) begin
                ack_delay--;
                if (ack_delay == 0) begin
                    tx_idle   = 1'b0;
                    pop_now   = 1'b1;
                    awaiting  = 1'b0;
                    busy_left = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 4);
                end else begin
                    tx_idle = 1'b1;
                end
            end else if (busy_left > 0) begin
                tx_idle = 1'b0;
                busy_left--;
            end else begin
                tx_idle = 1'b1;
            end
            rx_valid = (cyc < 3000) && ($urandom_range(0, 99) < 45);
            rx_data  = 8'($urandom_range(0, 255));
            clr_ovr  = ($urandom_range(0, 99) < 6);
            tick();
            full_before = (q.size() == DEPTH);
            if (pop_now) void'(q.pop_front());
            if (rx_valid) begin
                if (!full_before || pop_now) q.push_back(rx_data);
                else exp_ovr = 1'b1;
            end
            if (clr_ovr && !(rx_valid && full_before && !pop_now)) exp_ovr = 1'b0;
        end
        rx_valid = 1'b0;
        clr_ovr  = 1'b0;
        chk("rand_drained_model", q.size(), 0);
        chk("rand_drained_dut", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
